// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA timing generator. Advances a horizontal/vertical beam
//               position on each pixel clock-enable. It produces registered
//               hsync, vsync, video_on, line_start and frame_start. Each of
//               these describes the same position as the counters shown in
//               the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] horizontal_num,
  output logic [9:0] vertical_num,
  output logic       line_start,
  output logic       frame_start
);

  // Frame geometry
  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The counters are 10 bits wide, so a longer line or frame cannot be represented
  if (c_H_TOTAL > 1024 || c_H_TOTAL < 1) begin : g_bad_h_total
    $error("vga_sync_gen: H_TOTAL must be in 1..1024");
  end
  if (c_V_TOTAL > 1024 || c_V_TOTAL < 1) begin : g_bad_v_total
    $error("vga_sync_gen: V_TOTAL must be in 1..1024");
  end

  // Last count value of each axis (the wrap point)
  localparam logic [9:0]  c_H_LAST   = 10'(c_H_TOTAL - 1);
  localparam logic [9:0]  c_V_LAST   = 10'(c_V_TOTAL - 1);

  // Window bounds are 11 bits wide so a bound equal to 1024 stays exact
  localparam logic [10:0] c_H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] c_HS_BEGIN = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] c_V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] c_VS_BEGIN = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_video_on;
  logic       r_line_start;
  logic       r_frame_start;

  logic        w_h_wrap;
  logic        w_v_wrap;
  logic [9:0]  w_h_next;
  logic [9:0]  w_v_next;
  logic [10:0] w_h_ext;
  logic [10:0] w_v_ext;
  logic        w_hs_window;
  logic        w_vs_window;
  logic        w_video_next;
  logic        w_hsync_next;
  logic        w_vsync_next;
  logic        w_line_next;
  logic        w_frame_next;

  // Next beam position and its decodes. Outputs are registered from the
  // next-state values, so they line up with the counters without any skew.
  always_comb begin
    w_h_wrap     = (r_h == c_H_LAST);
    w_v_wrap     = (r_v == c_V_LAST);
    w_h_next     = w_h_wrap ? 10'd0 : r_h + 10'd1;
    w_v_next     = r_v;
    if (w_h_wrap) begin
      w_v_next = w_v_wrap ? 10'd0 : r_v + 10'd1;
    end
    w_h_ext      = {1'b0, w_h_next};
    w_v_ext      = {1'b0, w_v_next};
    w_hs_window  = (w_h_ext >= c_HS_BEGIN) && (w_h_ext < c_HS_END);
    w_vs_window  = (w_v_ext >= c_VS_BEGIN) && (w_v_ext < c_VS_END);
    w_video_next = (w_h_ext < c_H_ACT) && (w_v_ext < c_V_ACT);
    w_hsync_next = w_hs_window ? HS_POL : ~HS_POL;
    w_vsync_next = w_vs_window ? VS_POL : ~VS_POL;
    w_line_next  = (w_h_next == 10'd0);
    w_frame_next = w_line_next && (w_v_next == 10'd0);
  end

  // Beam state. Reset parks the beam at the last back-porch position, so
  // the first pixel tick afterwards lands on (0,0). Pulses last one clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h           <= c_H_LAST;
      r_v           <= c_V_LAST;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_video_on    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (pix_ce) begin
      r_h           <= w_h_next;
      r_v           <= w_v_next;
      r_hsync       <= w_hsync_next;
      r_vsync       <= w_vsync_next;
      r_video_on    <= w_video_next;
      r_line_start  <= w_line_next;
      r_frame_start <= w_frame_next;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign hsync          = r_hsync;
  assign vsync          = r_vsync;
  assign video_on       = r_video_on;
  assign horizontal_num = r_h;
  assign vertical_num   = r_v;
  assign line_start     = r_line_start;
  assign frame_start    = r_frame_start;

endmodule
`default_nettype wire
